// File: rtl/updown_count_monitor.sv
// Passive observer of an up/down counter bus: classifies each sampled transition,
// tracks a locked count direction and accumulates illegal-jump errors.
module updown_count_monitor #(
  parameter int WIDTH     = 4,
  parameter int ERR_CNT_W = 8,
  parameter int LOCK_LEN  = 3
) (
  input  logic                 Clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     Count,
  input  logic                 enable,
  input  logic                 clear_err,
  output logic                 step_up,
  output logic                 step_down,
  output logic                 wrap,
  output logic                 dir_change,
  output logic                 locked,
  output logic                 dir_up,
  output logic                 dir_down,
  output logic                 err,
  output logic [ERR_CNT_W-1:0] err_count
);

  // state     | meaning
  // ACQ       | first enabled sample only captures prev
  // SYNC      | counting consecutive same-direction steps toward lock
  // LOCK_UP   | LOCK_LEN consecutive up steps seen
  // LOCK_DOWN | LOCK_LEN consecutive down steps seen
  typedef enum logic [1:0] {ACQ, SYNC, LOCK_UP, LOCK_DOWN} state_t;

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [3:0]       run;
  logic             rdir;

  logic [WIDTH-1:0] delta;
  logic             is_up, is_down, is_hold, is_jump;
  logic [3:0]       run_nxt;

  always_comb begin
    delta   = Count - prev;
    is_up   = (delta == WIDTH'(1));
    is_down = (delta == {WIDTH{1'b1}});
    is_hold = (delta == '0);
    is_jump = !(is_up || is_down || is_hold);
    // a step continues the run if it matches the run direction or starts a fresh run
    run_nxt = ((rdir == is_up) || (run == 4'd0)) ? run + 4'd1 : 4'd1;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      state      <= ACQ;
      prev       <= '0;
      run        <= '0;
      rdir       <= 1'b0;
      step_up    <= 1'b0;
      step_down  <= 1'b0;
      wrap       <= 1'b0;
      dir_change <= 1'b0;
      locked     <= 1'b0;
      dir_up     <= 1'b0;
      dir_down   <= 1'b0;
      err        <= 1'b0;
      err_count  <= '0;
    end else begin
      step_up    <= 1'b0;
      step_down  <= 1'b0;
      wrap       <= 1'b0;
      dir_change <= 1'b0;
      if (clear_err) begin
        err       <= 1'b0;
        err_count <= '0;
      end
      if (!enable) begin
        state    <= ACQ;
        run      <= '0;
        locked   <= 1'b0;
        dir_up   <= 1'b0;
        dir_down <= 1'b0;
      end else begin
        prev <= Count;
        if (state == ACQ) begin
          state <= SYNC;
        end else begin
          step_up   <= is_up;
          step_down <= is_down;
          wrap      <= (is_up && Count == '0) || (is_down && Count == {WIDTH{1'b1}});
          if (is_jump) begin
            // a jump on the same edge as clear_err still counts as the first error
            err       <= 1'b1;
            err_count <= clear_err ? ERR_CNT_W'(1)
                       : (&err_count) ? err_count : err_count + ERR_CNT_W'(1);
            state     <= SYNC;
            run       <= '0;
            locked    <= 1'b0;
            dir_up    <= 1'b0;
            dir_down  <= 1'b0;
          end else if (state == SYNC) begin
            if (is_up || is_down) begin
              run  <= run_nxt;
              rdir <= is_up;
              if (run_nxt >= 4'(LOCK_LEN)) begin
                state    <= is_up ? LOCK_UP : LOCK_DOWN;
                locked   <= 1'b1;
                dir_up   <= is_up;
                dir_down <= is_down;
              end
            end
          end else if ((state == LOCK_UP && is_down) || (state == LOCK_DOWN && is_up)) begin
            dir_change <= 1'b1;
            state      <= SYNC;
            run        <= 4'd1;
            rdir       <= is_up;
            locked     <= 1'b0;
            dir_up     <= 1'b0;
            dir_down   <= 1'b0;
          end
        end
      end
    end
  end

endmodule
